cfg_packer_avlstrm: RTL and testbench

//  Host-side source of the stats/config record stream: takes MMIO register writes
//  {addr,val} and emits one stats_t record per write on an Avalon-ST tx port. The

---
 rtl/cfg_packer_avlstrm_if.sv | 18 +
 rtl/cfg_packer_avlstrm.sv | 151 +++++++++++++++
 tb/tb_cfg_packer_avlstrm.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_packer_avlstrm_if.sv
// avl_stream_if: single-channel Avalon-ST link carrying stats_t records.
//   valid/sop/eop/data : source -> sink
//   ready              : sink -> source
// tx/master is the source view, rx/slave the sink view.
interface avl_stream_if #(
   parameter int DW = 40
);
   logic          valid;
   logic          ready;
   logic          sop;
   logic          eop;
   logic [DW-1:0] data;

   modport tx     (output valid, sop, eop, data, input  ready);
   modport rx     (input  valid, sop, eop, data, output ready);
   modport master (output valid, sop, eop, data, input  ready);
   modport slave  (input  valid, sop, eop, data, output ready);
endinterface

// File: rtl/cfg_packer_avlstrm.sv
// cfg_packer_avlstrm: host-side source of the stats/config record stream.
// Turns MMIO writes {addr,val} into single-beat stats_t records on an Avalon-ST
// port, keeps a shadow copy of every register for readback, and replays the
// whole shadow file (ascending addr) when REPLAY_ADDR is written.
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   write/writeaddr/writedata/waitrequest   host write port (host holds while stalled)
//   readaddr/readdata                       shadow readback, 1-cycle latency
//   fifo_level    registered record FIFO occupancy
//   cfg_out       record stream, data = {addr[7:0], val[31:0]}
module cfg_packer_avlstrm #(
   parameter int         FIFO_DEPTH  = 8,
   parameter int         NUM_REGS    = 64,
   parameter logic [7:0] REPLAY_ADDR = 8'hFF
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          write,
   input  logic [7:0]                    writeaddr,
   input  logic [31:0]                   writedata,
   output logic                          waitrequest,
   input  logic [7:0]                    readaddr,
   output logic [31:0]                   readdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   avl_stream_if.tx                      cfg_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
   localparam logic [8:0]    NREGS9   = 9'(NUM_REGS);

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] val;
   } stats_t;

   typedef enum logic {IDLE, REPLAY} state_t;

   stats_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_q;
   logic [31:0]   shadow [NUM_REGS];

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   logic   full, empty, pop, push;
   logic   host_acc, host_push, is_replay_cmd, wr_in_range, rd_in_range;
   logic   rep_push;
   stats_t push_rec;

   assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
   assign empty = (level_q == '0);

   // Host is stalled for the whole replay so replay records are never
   // interleaved with new writes.
   assign waitrequest = full || (state_q == REPLAY);

   assign host_acc      = write && !waitrequest;
   assign is_replay_cmd = (writeaddr == REPLAY_ADDR);
   assign wr_in_range   = ({1'b0, writeaddr} < NREGS9);
   assign rd_in_range   = ({1'b0, readaddr} < NREGS9);
   // Replay command wins even if REPLAY_ADDR were inside the register range.
   assign host_push     = host_acc && !is_replay_cmd && wr_in_range;

   assign pop = !empty && cfg_out.ready;

   // ---------------- replay FSM ----------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rep_push = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_acc && is_replay_cmd) begin
               state_d = REPLAY;
               idx_d   = '0;
            end
         end
         REPLAY: begin
            // A same-cycle pop frees a slot, so a full FIFO can still take a record.
            if (!full || pop) begin
               rep_push = 1'b1;
               if (idx_q == LAST_IDX) state_d = IDLE;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // host_push and rep_push are exclusive: host is stalled during REPLAY.
   assign push = host_push || rep_push;

   always_comb begin
      push_rec = '{addr: writeaddr, val: writedata};
      if (rep_push) push_rec = '{addr: 8'(idx_q), val: shadow[idx_q]};
   end

   // ---------------- record FIFO ----------------
   // Storage has no reset; pointers/level define what is valid.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= push_rec;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign fifo_level    = level_q;
   assign cfg_out.valid = !empty;
   assign cfg_out.sop   = !empty;
   assign cfg_out.eop   = !empty;
   assign cfg_out.data  = mem[rd_ptr];

   // ---------------- shadow file + readback ----------------
   // readdata samples the pre-edge shadow, so a same-cycle write reads old data.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
         readdata <= '0;
      end else begin
         if (host_push) shadow[writeaddr[IW-1:0]] <= writedata;
         readdata <= rd_in_range ? shadow[readaddr[IW-1:0]] : 32'h0;
      end
   end

endmodule

// File: tb/tb_cfg_packer_avlstrm.sv
module tb_cfg_packer_avlstrm;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        write;
   logic [7:0]  writeaddr;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [7:0]  readaddr;
   logic [31:0] readdata;
   logic [3:0]  fifo_level;

   avl_stream_if #(.DW(40)) cfg_if ();

   cfg_packer_avlstrm #(
      .FIFO_DEPTH(8), .NUM_REGS(64), .REPLAY_ADDR(8'hFF)
   ) dut (
      .Clk(Clk), .Rst(Rst), .write(write), .writeaddr(writeaddr),
      .writedata(writedata), .waitrequest(waitrequest), .readaddr(readaddr),
      .readdata(readdata), .fifo_level(fifo_level), .cfg_out(cfg_if.tx)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat collector and hold-stability check, sampled mid-cycle.
   logic [39:0] got[$];
   logic        prev_stall = 1'b0;
   logic [39:0] prev_data  = '0;
   initial forever begin
      @(negedge Clk);
      if (Rst) prev_stall = 1'b0;
      else begin
         if (prev_stall && cfg_if.valid) chk("hold_data", 64'(cfg_if.data), 64'(prev_data));
         if (cfg_if.valid && cfg_if.ready) got.push_back(cfg_if.data);
         prev_stall = cfg_if.valid && !cfg_if.ready;
         prev_data  = cfg_if.data;
      end
   end

   // Holds the current write until accepted, then drops the strobe.
   task automatic accept();
      int n = 0;
      @(negedge Clk);
      while (waitrequest && n < 300) begin @(negedge Clk); n++; end
      if (waitrequest) chk("wr_timeout", 1, 0);
      @(posedge Clk); #1;
      write = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      writeaddr = a; writedata = d; write = 1'b1;
      accept();
   endtask

   task automatic drain();
      int n = 0;
      @(negedge Clk);
      while ((cfg_if.valid || fifo_level != 0 || waitrequest) && n < 500) begin
         @(negedge Clk); n++;
      end
      if (n >= 500) chk("drain_timeout", 1, 0);
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ev;
      int lo;
      int n;
      write = 0; writeaddr = 0; writedata = 0; readaddr = 0; cfg_if.ready = 1'b1;
      do_reset();
      @(negedge Clk);
      chk("rst_valid", cfg_if.valid, 0);
      chk("rst_sop",   cfg_if.sop,   0);
      chk("rst_level", fifo_level,   0);
      chk("rst_wait",  waitrequest,  0);
      chk("rst_rdata", readdata,     0);
      @(posedge Clk); #1;

      // T1: single write, beat next cycle, readback
      wr(8'd3, 32'hDEAD);
      @(negedge Clk);
      chk("t1_valid", cfg_if.valid, 1);
      chk("t1_sop",   cfg_if.sop,   1);
      chk("t1_eop",   cfg_if.eop,   1);
      chk("t1_data",  cfg_if.data,  {8'd3, 32'hDEAD});
      readaddr = 8'd3;
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("t1_rdata", readdata, 32'hDEAD);
      @(posedge Clk); #1;
      drain();
      got.delete();

      // T2: fill with ready=0, 9th write stalls
      cfg_if.ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(8'(i), 32'h100 + 32'(i));
      writeaddr = 8'd8; writedata = 32'h108; write = 1'b1;
      @(negedge Clk);
      chk("t2_wait",  waitrequest, 1);
      chk("t2_level", fifo_level,  8);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("t2_wait2", waitrequest, 1);
      @(posedge Clk); #1;
      cfg_if.ready = 1'b1;
      accept();
      drain();
      chk("t2_count", got.size(), 9);
      for (int i = 0; i < 9 && i < got.size(); i++)
         chk("t2_beat", got[i], {8'(i), 32'h100 + 32'(i)});
      got.delete();

      // T3: writes then replay from a clean shadow
      do_reset();
      wr(8'd2, 32'd5);
      wr(8'd2, 32'd9);
      wr(8'hFF, 32'h0);
      lo = 0;
      repeat (55) begin @(negedge Clk); if (!waitrequest) lo++; end
      chk("t3_wait_low_cycles", lo, 0);
      @(posedge Clk); #1;
      drain();
      chk("t3_count", got.size(), 66);
      if (got.size() == 66) begin
         chk("t3_b0", got[0], {8'd2, 32'd5});
         chk("t3_b1", got[1], {8'd2, 32'd9});
         for (int i = 0; i < 64; i++)
            chk("t3_replay", got[2+i], {8'(i), (i == 2) ? 32'd9 : 32'd0});
      end
      got.delete();

      // T4: replay with ready toggling every cycle
      wr(8'd5, 32'h55);
      wr(8'd63, 32'h6363);
      drain();
      got.delete();
      wr(8'hFF, 32'h0);
      n = 0;
      while (got.size() < 64 && n < 2000) begin
         @(posedge Clk); #1;
         cfg_if.ready = ~cfg_if.ready;
         n++;
      end
      cfg_if.ready = 1'b1;
      drain();
      chk("t4_count", got.size(), 64);
      for (int i = 0; i < 64 && i < got.size(); i++) begin
         ev = (i == 2) ? 32'd9 : (i == 5) ? 32'h55 : (i == 63) ? 32'h6363 : 32'd0;
         chk("t4_replay", got[i], {8'(i), ev});
      end
      got.delete();

      // T5: out-of-range address is dropped
      wr(8'd100, 32'hBAD);
      @(negedge Clk);
      chk("t5_valid", cfg_if.valid, 0);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("t5_level", fifo_level, 0);
      chk("t5_beats", got.size(), 0);
      readaddr = 8'd36;
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("t5_alias", readdata, 0);
      readaddr = 8'd100;
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("t5_oor_rd", readdata, 0);
      @(posedge Clk); #1;

      // T6: reset mid-replay at idx=20
      wr(8'hFF, 32'h0);
      repeat (20) @(posedge Clk);
      @(negedge Clk);
      chk("t6_in_replay", waitrequest, 1);
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("t6_valid", cfg_if.valid, 0);
      chk("t6_level", fifo_level,   0);
      chk("t6_wait",  waitrequest,  0);
      got.delete();
      for (int i = 0; i < 64; i++) begin
         readaddr = 8'(i);
         @(posedge Clk); #1;
         @(negedge Clk);
         chk("t6_rdata", readdata, 0);
      end
      @(posedge Clk); #1;
      wr(8'd7, 32'd77);
      @(negedge Clk);
      chk("t6_post_valid", cfg_if.valid, 1);
      chk("t6_post_data",  cfg_if.data,  {8'd7, 32'd77});
      @(posedge Clk); #1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
